// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues PC requests to instruction memory, buffers in-order
// responses with their PC in a DEPTH-entry ring, and flushes younger state on redirect.
module fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic [1:0]        pc_act_o,
  input  logic [1:0]        br_act_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [DATA_W-1:0] imem_resp_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_inst_o,
  output logic [ADDR_W-1:0] out_pc_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    PC_NONE   = 2'd0,
    PC_INC    = 2'd1,
    PC_OFFSET = 2'd2,
    PC_JUMP   = 2'd3
  } pc_action_e;

  pc_action_e br_act;
  pc_action_e pc_act;

  logic [ADDR_W-1:0] slot_pc_q   [DEPTH];
  logic [DATA_W-1:0] slot_inst_q [DEPTH];

  logic [DEPTH-1:0] filled_q,    filled_d;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0]    head_ptr_q,  head_ptr_d;
  logic [CW-1:0]    alloc_cnt_q, alloc_cnt_d;
  logic [CW-1:0]    discard_q,   discard_d;

  logic [CW-1:0] filled_cnt;
  logic [CW:0]   occupancy;
  logic          redirect;
  logic          credit;
  logic          fire;
  logic          pop;
  logic          resp_fill;

  assign br_act     = pc_action_e'(br_act_i);
  assign redirect   = (br_act == PC_OFFSET) || (br_act == PC_JUMP);

  // Slots still owed a response (including ones to be discarded) hold credit.
  assign occupancy  = {1'b0, alloc_cnt_q} + {1'b0, discard_q};
  assign credit     = occupancy < DEPTH_C;

  assign imem_req_valid_o = credit && !redirect && !rst_i;
  assign imem_req_addr_o  = pc_addr_i;
  assign fire             = imem_req_valid_o && imem_req_ready_i;

  assign out_valid_o = filled_q[head_ptr_q] && !redirect && !rst_i;
  assign out_inst_o  = slot_inst_q[head_ptr_q];
  assign out_pc_o    = slot_pc_q[head_ptr_q];
  assign pop         = out_valid_o && out_ready_i;

  assign resp_fill   = imem_resp_valid_i && (discard_q == '0) && !redirect;
  assign filled_cnt  = CW'($countones(filled_q));

  always_comb begin
    pc_act = PC_NONE;
    if (rst_i) begin
      pc_act = PC_NONE;
    end else if (redirect) begin
      pc_act = br_act;
    end else if (fire) begin
      pc_act = PC_INC;
    end
  end

  assign pc_act_o = pc_act;

  always_comb begin
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    alloc_cnt_d = alloc_cnt_q;
    discard_d   = discard_q;
    if (redirect) begin
      // Everything allocated but not yet answered (minus a response landing now)
      // is still in flight and must be dropped when it returns.
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      alloc_cnt_d = '0;
      discard_d   = alloc_cnt_q - filled_cnt + discard_q - CW'(imem_resp_valid_i);
    end else begin
      if (imem_resp_valid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d           = fill_ptr_q + 1'b1;
        end
      end
      if (pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + 1'b1;
      end
      if (fire) begin
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + 1'b1;
      end
      alloc_cnt_d = alloc_cnt_q + CW'(fire) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      alloc_cnt_q <= '0;
      discard_q   <= '0;
    end else begin
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      alloc_cnt_q <= alloc_cnt_d;
      discard_q   <= discard_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by filled_q.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      slot_pc_q[alloc_ptr_q] <= pc_addr_i;
    end
    if (resp_fill && !rst_i) begin
      slot_inst_q[fill_ptr_q] <= imem_resp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-based reference model of the fetch buffer,
// a PC register, and an in-order variable-latency instruction memory.
module tb_fetch_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst_i;
  logic [ADDR_W-1:0] pc_addr_i;
  logic [1:0]        pc_act_o;
  logic [1:0]        br_act_i;
  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [ADDR_W-1:0] imem_req_addr_o;
  logic              imem_resp_valid_i;
  logic [DATA_W-1:0] imem_resp_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_inst_o;
  logic [ADDR_W-1:0] out_pc_o;

  fetch_queue #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .pc_addr_i        (pc_addr_i),
    .pc_act_o         (pc_act_o),
    .br_act_i         (br_act_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_inst_o       (out_inst_o),
    .out_pc_o         (out_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  ent_t  mq[$];
  mrsp_t mem[$];
  int    discard;
  logic [31:0] pc;
  int    cyc;
  int    last_due;
  logic [31:0] seq;

  int checks;
  int errors;

  int   p_ready, p_oready, p_br, p_rst_pm, lat_min, lat_max;
  bit   rst_force;
  logic [1:0]  force_br;
  logic [31:0] force_tgt;

  int          dut_fires, dut_pops;
  logic [31:0] last_fire_addr, first_pop_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit          redirect, credit, e_req, fire, e_ov, pop, resp;
    logic [1:0]  e_act;
    logic [31:0] tgt, off;
    int          unf, lat, due;
    ent_t        e;
    mrsp_t       r;

    @(negedge clk);
    rst_i            = rst_force || (int'($urandom_range(0, 999)) < p_rst_pm);
    imem_req_ready_i = int'($urandom_range(0, 99)) < p_ready;
    out_ready_i      = int'($urandom_range(0, 99)) < p_oready;
    off = (32'($urandom_range(0, 63)) << 2) - 32'd128;
    if (force_br != 2'd0) begin
      br_act_i = force_br;
      tgt      = force_tgt;
    end else begin
      br_act_i = (int'($urandom_range(0, 99)) < p_br) ? 2'($urandom_range(2, 3)) : 2'd0;
      tgt      = (br_act_i == 2'd3) ? ($urandom & 32'hFFFF_FFFC) : (pc + off);
    end
    force_br = 2'd0;
    if (mem.size() > 0 && mem[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem[0].data;
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
    end
    resp      = imem_resp_valid_i;
    pc_addr_i = pc;

    #1;
    redirect = br_act_i[1];
    credit   = (mq.size() + discard) < DEPTH;
    e_req    = credit && !redirect && !rst_i;
    fire     = e_req && imem_req_ready_i;
    e_act    = rst_i ? 2'd0 : redirect ? br_act_i : fire ? 2'd1 : 2'd0;
    e_ov     = !rst_i && !redirect && mq.size() > 0 && mq[0].filled;
    pop      = e_ov && out_ready_i;

    check_eq("req_valid", 64'(imem_req_valid_o), 64'(e_req));
    check_eq("pc_act", 64'(pc_act_o), 64'(e_act));
    check_eq("out_valid", 64'(out_valid_o), 64'(e_ov));
    if (e_req) check_eq("req_addr", 64'(imem_req_addr_o), 64'(pc));
    if (e_ov) begin
      check_eq("out_pc", 64'(out_pc_o), 64'(mq[0].pc));
      check_eq("out_inst", 64'(out_inst_o), 64'(mq[0].inst));
    end
    if (!rst_i) begin
      if (imem_req_valid_o && imem_req_ready_i) begin
        dut_fires++;
        last_fire_addr = imem_req_addr_o;
      end
      if (out_valid_o && out_ready_i) begin
        if (dut_pops == 0) first_pop_pc = out_pc_o;
        dut_pops++;
      end
    end

    @(posedge clk);
    if (resp) void'(mem.pop_front());
    if (rst_i) begin
      mq.delete();
      mem.delete();
      discard  = 0;
      pc       = 32'h0;
      last_due = cyc;
    end else if (redirect) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      discard = unf + discard - (resp ? 1 : 0);
      mq.delete();
      pc = tgt;
    end else begin
      if (resp) begin
        if (discard > 0) begin
          discard--;
        end else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              e        = mq[i];
              e.filled = 1'b1;
              e.inst   = imem_resp_data_i;
              mq[i]    = e;
              break;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (fire) begin
        e.pc     = pc;
        e.inst   = 32'h0;
        e.filled = 1'b0;
        mq.push_back(e);
        lat      = int'($urandom_range(lat_min, lat_max));
        due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        r.due    = due;
        r.data   = {seq[15:0], pc[17:2]};
        mem.push_back(r);
        seq      = seq + 32'd1;
        pc       = pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_force = 1'b1;
    step();
    step();
    rst_force    = 1'b0;
    dut_fires    = 0;
    dut_pops     = 0;
    first_pop_pc = 32'hDEAD_BEEF;
  endtask

  task automatic clear_counts();
    dut_fires    = 0;
    dut_pops     = 0;
    first_pop_pc = 32'hDEAD_BEEF;
  endtask

  initial begin
    rst_i = 1'b1; pc_addr_i = '0; br_act_i = 2'd0; imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0; imem_resp_data_i = '0; out_ready_i = 1'b0;
    discard = 0; pc = 32'h0; cyc = 0; last_due = 0; seq = 32'h0;
    checks = 0; errors = 0;
    rst_force = 1'b0; force_br = 2'd0; force_tgt = 32'h0;
    dut_fires = 0; dut_pops = 0; last_fire_addr = 32'h0; first_pop_pc = 32'hDEAD_BEEF;
    p_ready = 100; p_oready = 100; p_br = 0; p_rst_pm = 0; lat_min = 1; lat_max = 1;

    // streaming, 1-cycle memory
    do_reset();
    repeat (30) step();
    check_eq("stream_fires", 64'(dut_fires), 64'd30);
    check_eq("stream_pops", 64'(dut_pops), 64'd28);
    check_eq("stream_first_pc", 64'(first_pop_pc), 64'h0);

    // backpressure: decode stalled
    do_reset();
    p_oready = 0;
    repeat (10) step();
    check_eq("bp_fires", 64'(dut_fires), 64'd4);
    check_eq("bp_last_addr", 64'(last_fire_addr), 64'hC);
    p_oready = 100;
    step();
    p_oready = 0;
    repeat (5) step();
    check_eq("bp_fires_after_pop", 64'(dut_fires), 64'd5);
    check_eq("bp_addr_after_pop", 64'(last_fire_addr), 64'h10);
    check_eq("bp_pops", 64'(dut_pops), 64'd1);

    // request stall
    do_reset();
    p_oready = 100;
    p_ready  = 0;
    repeat (5) step();
    check_eq("stall_fires", 64'(dut_fires), 64'd0);
    p_ready = 100;
    repeat (3) step();
    check_eq("stall_resume_fires", 64'(dut_fires), 64'd3);
    check_eq("stall_resume_addr", 64'(last_fire_addr), 64'h8);

    // flush with two requests in flight, 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    force_br = 2'd3; force_tgt = 32'h100;
    step();
    clear_counts();
    repeat (12) step();
    check_eq("flush_first_pc", 64'(first_pop_pc), 64'h100);

    // redirect coinciding with a response, 2-cycle memory
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (2) step();
    force_br = 2'd3; force_tgt = 32'h200;
    step();
    clear_counts();
    repeat (12) step();
    check_eq("coincide_first_pc", 64'(first_pop_pc), 64'h200);

    // reset mid-stream, then stream again
    do_reset();
    lat_min = 1; lat_max = 1;
    p_oready = 0;
    repeat (4) step();
    rst_force = 1'b1;
    step();
    rst_force = 1'b0;
    clear_counts();
    p_oready = 100;
    repeat (30) step();
    check_eq("rst_stream_fires", 64'(dut_fires), 64'd30);
    check_eq("rst_stream_pops", 64'(dut_pops), 64'd28);
    check_eq("rst_stream_first_pc", 64'(first_pop_pc), 64'h0);

    // random mix
    do_reset();
    p_ready = 70; p_oready = 60; p_br = 4; p_rst_pm = 5; lat_min = 1; lat_max = 4;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
